// File: rtl/spike_time_encoder.sv
// spike_time_encoder
// Turns one packed vector of per-line spike times into active-low race-logic
// spike lines over one gamma wave. A one-entry pending buffer accepts the next
// wave while the current one plays, so back-to-back waves are separated by a
// single GAP cycle. Every output is driven straight from a flop. Each output
// flop is loaded with the decode of the next-state values, so the outputs line
// up with the state they describe.
module spike_time_encoder #(
  parameter int NUM_SPIKES = 4,
  parameter int TIME_W     = 4,
  parameter int GAMMA_LEN  = 8,
  parameter int CNT_W      = $clog2(NUM_SPIKES + 1)
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SPIKES*TIME_W-1:0] spike_times_in,
  output logic [NUM_SPIKES-1:0]        should_spike_in_l,
  output logic [CNT_W-1:0]             spike_count,
  output logic [TIME_W-1:0]            time_cnt,
  output logic                         wave_done
);

  localparam int                TIMES_W = NUM_SPIKES * TIME_W;
  // Last RUN time. Any line whose time is above this value cannot fire within a wave.
  localparam logic [TIME_W-1:0] LAST_T  = TIME_W'(GAMMA_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Registered state
  state_t              state_r;
  logic [TIMES_W-1:0]  pend_r;
  logic                pend_full_r;
  logic [TIMES_W-1:0]  active_r;
  logic [TIME_W-1:0]   time_r;
  logic [NUM_SPIKES-1:0] lines_l_r;
  logic [CNT_W-1:0]    count_r;
  logic                done_r;
  logic                ready_r;

  // Next-state values
  state_t              state_nxt_s;
  logic [TIMES_W-1:0]  pend_nxt_s;
  logic                pend_full_nxt_s;
  logic [TIMES_W-1:0]  active_nxt_s;
  logic [TIME_W-1:0]   time_nxt_s;
  logic [NUM_SPIKES-1:0] lines_l_nxt_s;
  logic [CNT_W-1:0]    count_nxt_s;
  logic                done_nxt_s;
  logic                accept_s;
  logic                load_s;

  // A line fires (drives 0) in RUN once its time has been reached.
  // Out-of-range times stay high for the whole wave.
  function automatic logic [NUM_SPIKES-1:0] decode_lines(
    input state_t             st,
    input logic [TIMES_W-1:0] times,
    input logic [TIME_W-1:0]  t
  );
    logic [NUM_SPIKES-1:0] l;
    logic [TIME_W-1:0]     ti;
    l = '1;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      ti = times[i*TIME_W +: TIME_W];
      if ((st == ST_RUN) && (ti <= LAST_T) && (ti <= t)) begin
        l[i] = 1'b0;
      end else begin
        l[i] = 1'b1;
      end
    end
    return l;
  endfunction

  // Count of fired (low) lines.
  function automatic logic [CNT_W-1:0] count_low(input logic [NUM_SPIKES-1:0] l);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      if (!l[i]) begin
        c = c + CNT_W'(1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Next-state logic: wave sequencing, the pending buffer handshake, and the output decode.
  always_comb begin
    state_nxt_s     = state_r;
    time_nxt_s      = time_r;
    active_nxt_s    = active_r;
    pend_nxt_s      = pend_r;
    pend_full_nxt_s = pend_full_r;
    load_s          = 1'b0;
    // ready_r is low whenever the buffer holds data, so an accept and a load never happen on the same edge.
    accept_s        = in_valid && ready_r;

    case (state_r)
      ST_IDLE: begin
        time_nxt_s = '0;
        if (pend_full_r) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (time_r == LAST_T) begin
          state_nxt_s = ST_GAP;
          time_nxt_s  = '0;
        end else begin
          state_nxt_s = ST_RUN;
          time_nxt_s  = time_r + TIME_W'(1);
        end
      end
      ST_GAP: begin
        time_nxt_s = '0;
        if (pend_full_r) begin
          state_nxt_s = ST_RUN;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        time_nxt_s  = '0;
      end
    endcase

    if (load_s) begin
      active_nxt_s = pend_r;
    end else begin
      active_nxt_s = active_r;
    end

    if (accept_s) begin
      pend_nxt_s      = spike_times_in;
      pend_full_nxt_s = 1'b1;
    end else if (load_s) begin
      pend_full_nxt_s = 1'b0;
    end else begin
      pend_full_nxt_s = pend_full_r;
    end

    lines_l_nxt_s = decode_lines(state_nxt_s, active_nxt_s, time_nxt_s);
    count_nxt_s   = count_low(lines_l_nxt_s);
    done_nxt_s    = (state_nxt_s == ST_GAP);
  end

  // FSM and output registers. Reset clears the state and discards both the pending and active waves.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_r     <= ST_IDLE;
      pend_r      <= '0;
      pend_full_r <= 1'b0;
      active_r    <= '0;
      time_r      <= '0;
      lines_l_r   <= '1;
      count_r     <= '0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_full_r <= pend_full_nxt_s;
      active_r    <= active_nxt_s;
      time_r      <= time_nxt_s;
      lines_l_r   <= lines_l_nxt_s;
      count_r     <= count_nxt_s;
      done_r      <= done_nxt_s;
      ready_r     <= !pend_full_nxt_s;
    end
  end

  assign in_ready          = ready_r;
  assign should_spike_in_l = lines_l_r;
  assign spike_count       = count_r;
  assign time_cnt          = time_r;
  assign wave_done         = done_r;

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench for spike_time_encoder (NUM_SPIKES=4, TIME_W=4, GAMMA_LEN=8).
module tb_spike_time_encoder;

  logic        clk;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] spike_times_in;
  logic [3:0]  should_spike_in_l;
  logic [2:0]  spike_count;
  logic [3:0]  time_cnt;
  logic        wave_done;

  int tests = 0;
  int fails = 0;

  // Expected lines for times {l0=0,l1=3,l2=7,l3=15}, RUN t=0..7
  logic [3:0] exp2 [0:7] = '{4'b1110, 4'b1110, 4'b1110, 4'b1100,
                             4'b1100, 4'b1100, 4'b1100, 4'b1000};
  logic [2:0] cnt2 [0:7] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};

  spike_time_encoder #(
    .NUM_SPIKES(4),
    .TIME_W    (4),
    .GAMMA_LEN (8)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .spike_times_in   (spike_times_in),
    .should_spike_in_l(should_spike_in_l),
    .spike_count      (spike_count),
    .time_cnt         (time_cnt),
    .wave_done        (wave_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eo, input logic [2:0] ec,
                     input logic [3:0] et, input logic ed, input logic er);
    tests++;
    assert (should_spike_in_l === eo) else begin
      fails++;
      $error("FAIL %s.lines observed=%b expected=%b", tag, should_spike_in_l, eo);
    end
    tests++;
    assert (spike_count === ec) else begin
      fails++;
      $error("FAIL %s.count observed=%0d expected=%0d", tag, spike_count, ec);
    end
    tests++;
    assert (time_cnt === et) else begin
      fails++;
      $error("FAIL %s.time observed=%0d expected=%0d", tag, time_cnt, et);
    end
    tests++;
    assert (wave_done === ed) else begin
      fails++;
      $error("FAIL %s.done observed=%b expected=%b", tag, wave_done, ed);
    end
    tests++;
    assert (in_ready === er) else begin
      fails++;
      $error("FAIL %s.ready observed=%b expected=%b", tag, in_ready, er);
    end
  endtask

  initial begin
    rst_l          = 1'b0;
    in_valid       = 1'b0;
    spike_times_in = 16'h0000;

    // 1. reset values
    #12;
    chk("reset", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_l = 1'b1;

    // 2. single wave {l0=0,l1=3,l2=7,l3=15}
    tick();
    in_valid       = 1'b1;
    spike_times_in = 16'hF730;
    tick();
    in_valid = 1'b0;
    chk("w1.accept", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++) begin
      tick();
      chk($sformatf("w1.run%0d", t), exp2[t], cnt2[t], 4'(t), 1'b0, 1'b1);
    end
    tick();
    chk("w1.gap", 4'b1111, 3'd0, 4'd0, 1'b1, 1'b1);
    tick();
    chk("w1.idle", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);

    // 3+4. wave A {1,2,5,9}; B {4,0,8,2} accepted at A t=2; D {7,7,7,7} held while full
    in_valid       = 1'b1;
    spike_times_in = 16'h9521;
    tick();
    in_valid = 1'b0;
    tick();
    chk("wa.t0", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("wa.t1", 4'b1110, 3'd1, 4'd1, 1'b0, 1'b1);
    tick();
    chk("wa.t2", 4'b1100, 3'd2, 4'd2, 1'b0, 1'b1);
    in_valid       = 1'b1;
    spike_times_in = 16'h2804;
    tick();
    chk("wa.t3", 4'b1100, 3'd2, 4'd3, 1'b0, 1'b0);
    spike_times_in = 16'h7777;
    tick();
    tick();
    chk("wa.t5", 4'b1000, 3'd3, 4'd5, 1'b0, 1'b0);
    tick();
    tick();
    chk("wa.t7", 4'b1000, 3'd3, 4'd7, 1'b0, 1'b0);
    tick();
    chk("wa.gap", 4'b1111, 3'd0, 4'd0, 1'b1, 1'b0);
    tick();
    chk("wb.t0", 4'b1101, 3'd1, 4'd0, 1'b0, 1'b1);
    tick();
    chk("wb.t1", 4'b1101, 3'd1, 4'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("wb.t2", 4'b0101, 3'd2, 4'd2, 1'b0, 1'b0);
    tick();
    tick();
    chk("wb.t4", 4'b0100, 3'd3, 4'd4, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("wb.t7", 4'b0100, 3'd3, 4'd7, 1'b0, 1'b0);
    tick();
    chk("wb.gap", 4'b1111, 3'd0, 4'd0, 1'b1, 1'b0);
    tick();
    chk("wd.t0", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    for (int t = 1; t < 7; t++) begin
      tick();
    end
    chk("wd.t6", 4'b1111, 3'd0, 4'd6, 1'b0, 1'b1);
    tick();
    chk("wd.t7", 4'b0000, 3'd4, 4'd7, 1'b0, 1'b1);
    tick();
    chk("wd.gap", 4'b1111, 3'd0, 4'd0, 1'b1, 1'b1);
    tick();
    chk("wd.idle", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);

    // 5. reset at RUN t=4 with a wave pending
    in_valid       = 1'b1;
    spike_times_in = 16'h3210;
    tick();
    in_valid = 1'b0;
    tick();
    chk("we.t0", 4'b1110, 3'd1, 4'd0, 1'b0, 1'b1);
    in_valid       = 1'b1;
    spike_times_in = 16'h0000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("we.t4", 4'b0000, 3'd4, 4'd4, 1'b0, 1'b0);
    rst_l = 1'b0;
    #1;
    chk("midrst", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    chk("postrst1", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("postrst2", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);
    tick();
    chk("postrst3", 4'b1111, 3'd0, 4'd0, 1'b0, 1'b1);

    // 6. all times zero
    in_valid       = 1'b1;
    spike_times_in = 16'h0000;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk($sformatf("wz.run%0d", t), 4'b0000, 3'd4, 4'(t), 1'b0, 1'b1);
    end
    tick();
    chk("wz.gap", 4'b1111, 3'd0, 4'd0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
